// File: rtl/jts16_ramreq.sv
// jts16_ramreq: one SDRAM slot shared by System 16A work RAM and VRAM.
// One access per chip-select rising edge, with a one-deep pending slot.
module jts16_ramreq #(
    parameter int             AW          = 14,
    parameter int             SDW         = 22,
    parameter logic [SDW-1:0] RAM_OFFSET  = 22'h0,
    parameter logic [SDW-1:0] VRAM_OFFSET = 22'h4000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ram_cs,
    input  logic           vram_cs,
    input  logic [AW:1]    addr,
    input  logic [15:0]    din,
    input  logic           UDSWn,
    input  logic           LDSWn,
    output logic [15:0]    dout,
    output logic           ram_ok,
    output logic [SDW-1:0] sdram_addr,
    output logic           sdram_req,
    output logic           sdram_we,
    output logic [15:0]    sdram_din,
    output logic [1:0]     sdram_dsn,
    input  logic           sdram_ack,
    input  logic           sdram_rdy,
    input  logic [15:0]    sdram_dout
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t         st;
    logic           cs, cs_l, start, busy, finish;
    logic           pend, aborted;
    logic [SDW-1:0] new_addr, pend_addr, src_addr;
    logic           new_we, pend_we, src_we;
    logic [1:0]     new_dsn, pend_dsn, src_dsn;
    logic [15:0]    pend_din, src_din;

    assign cs       = ram_cs | vram_cs;
    assign start    = cs & ~cs_l;
    assign busy     = st != IDLE;
    assign finish   = (st == REQ  && sdram_ack && sdram_rdy) ||
                      (st == WAIT && sdram_rdy);

    assign new_addr = (ram_cs ? RAM_OFFSET : VRAM_OFFSET) + SDW'(addr);
    assign new_we   = ~(UDSWn & LDSWn);
    assign new_dsn  = new_we ? {UDSWn, LDSWn} : 2'b00;

    // A live edge in IDLE beats a stale pending entry
    assign src_addr = start ? new_addr : pend_addr;
    assign src_we   = start ? new_we   : pend_we;
    assign src_dsn  = start ? new_dsn  : pend_dsn;
    assign src_din  = start ? din      : pend_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            cs_l       <= 1'b0;
            pend       <= 1'b0;
            aborted    <= 1'b0;
            pend_addr  <= '0;
            pend_we    <= 1'b0;
            pend_dsn   <= 2'b11;
            pend_din   <= 16'h0;
            dout       <= 16'hffff;
            ram_ok     <= 1'b0;
            sdram_req  <= 1'b0;
            sdram_we   <= 1'b0;
            sdram_dsn  <= 2'b11;
            sdram_addr <= '0;
            sdram_din  <= 16'h0;
        end else begin
            cs_l <= cs;
            if (busy && start) begin
                pend      <= 1'b1;
                pend_addr <= new_addr;
                pend_we   <= new_we;
                pend_dsn  <= new_dsn;
                pend_din  <= din;
            end
            // The SDRAM access cannot be cancelled, only its ram_ok
            if ((st == REQ || st == WAIT) && !cs)
                aborted <= 1'b1;
            if (finish) begin
                st     <= DONE;
                ram_ok <= cs & ~aborted;
                if (!sdram_we)
                    dout <= sdram_dout;
            end
            unique case (st)
                IDLE: begin
                    ram_ok <= 1'b0;
                    if (start || pend) begin
                        st         <= REQ;
                        sdram_req  <= 1'b1;
                        sdram_addr <= src_addr;
                        sdram_we   <= src_we;
                        sdram_dsn  <= src_dsn;
                        sdram_din  <= src_din;
                        pend       <= 1'b0;
                        aborted    <= ~cs;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (!sdram_rdy)
                            st <= WAIT;
                    end
                end
                WAIT: begin
                end
                DONE: begin
                    if (cs && !aborted) begin
                        ram_ok <= 1'b1;
                    end else begin
                        ram_ok <= 1'b0;
                        st     <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jts16_ramreq.sv
// Bench for jts16_ramreq: directed scenarios plus random bus cycles
// checked against a transaction-level model of the SDRAM slot.
module tb_jts16_ramreq;
    localparam int             AW   = 14;
    localparam int             SDW  = 22;
    localparam logic [SDW-1:0] ROFF = 22'h0;
    localparam logic [SDW-1:0] VOFF = 22'h3ff000;

    logic           clk = 1'b0;
    logic           rst;
    logic           ram_cs, vram_cs;
    logic [AW:1]    addr;
    logic [15:0]    din;
    logic           UDSWn, LDSWn;
    logic [15:0]    dout;
    logic           ram_ok;
    logic [SDW-1:0] sdram_addr;
    logic           sdram_req, sdram_we;
    logic [15:0]    sdram_din;
    logic [1:0]     sdram_dsn;
    logic           sdram_ack, sdram_rdy;
    logic [15:0]    sdram_dout;

    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] exp_dout;

    jts16_ramreq #(
        .AW(AW), .SDW(SDW), .RAM_OFFSET(ROFF), .VRAM_OFFSET(VOFF)
    ) dut (
        .clk(clk), .rst(rst), .ram_cs(ram_cs), .vram_cs(vram_cs),
        .addr(addr), .din(din), .UDSWn(UDSWn), .LDSWn(LDSWn),
        .dout(dout), .ram_ok(ram_ok), .sdram_addr(sdram_addr),
        .sdram_req(sdram_req), .sdram_we(sdram_we),
        .sdram_din(sdram_din), .sdram_dsn(sdram_dsn),
        .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
        .sdram_dout(sdram_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [SDW-1:0] exp_addr(input bit ram,
                                                input logic [AW:1] a);
        longint s;
        s = longint'(ram ? ROFF : VOFF) + longint'(a);
        return SDW'(s % (longint'(1) << SDW));
    endfunction

    task automatic idle(input int n, input bit spur);
        repeat (n) begin
            if (spur) begin
                sdram_ack = 1'($urandom);
                sdram_rdy = 1'($urandom);
            end
            @(negedge clk);
            sdram_ack = 1'b0;
            sdram_rdy = 1'b0;
            chk("idle", {sdram_req, ram_ok, dout}, {2'b00, exp_dout});
        end
    endtask

    // One CPU bus cycle with an SDRAM responder of given ack/rdy delays
    task automatic xact(input bit ram, input logic [AW:1] a,
                        input logic [15:0] d, input bit u, input bit l,
                        input int ack_dly, input int rdy_dly,
                        input logic [15:0] rdata, input bit abort,
                        input int hold, input string tag);
        logic [SDW-1:0] ea;
        bit             we, ab;
        logic [1:0]     dsn;
        int             n;
        ea  = exp_addr(ram, a);
        we  = !(u && l);
        dsn = we ? {u, l} : 2'b00;
        ab  = abort && rdy_dly > 0;
        ram_cs = ram; vram_cs = !ram; addr = a; din = d;
        UDSWn = u; LDSWn = l;
        n = 0;
        @(negedge clk);
        while (sdram_req !== 1'b1 && n < 4) begin
            n++;
            @(negedge clk);
        end
        chk({tag, ".req"}, sdram_req, 1);
        chk({tag, ".addr"}, sdram_addr, ea);
        chk({tag, ".we"}, sdram_we, we);
        chk({tag, ".dsn"}, sdram_dsn, dsn);
        chk({tag, ".din"}, sdram_din, d);
        addr = AW'($urandom);
        din  = 16'($urandom);
        repeat (ack_dly) begin
            @(negedge clk);
            chk({tag, ".hold"},
                {sdram_req, sdram_we, sdram_dsn, sdram_addr},
                {1'b1, we, dsn, ea});
            chk({tag, ".hold_din"}, {ram_ok, sdram_din}, {1'b0, d});
        end
        sdram_ack  = 1'b1;
        sdram_rdy  = (rdy_dly == 0);
        sdram_dout = rdata;
        @(negedge clk);
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        chk({tag, ".ackreq"}, sdram_req, 0);
        if (rdy_dly > 0) begin
            chk({tag, ".early"}, ram_ok, 0);
            if (ab) begin
                ram_cs = 1'b0;
                vram_cs = 1'b0;
            end
            repeat (rdy_dly - 1) begin
                @(negedge clk);
                chk({tag, ".wait"}, {sdram_req, ram_ok}, 0);
            end
            sdram_rdy  = 1'b1;
            sdram_dout = rdata;
            @(negedge clk);
            sdram_rdy = 1'b0;
        end
        sdram_dout = 16'($urandom);
        if (!we)
            exp_dout = rdata;
        chk({tag, ".ok"}, ram_ok, !ab);
        chk({tag, ".dout"}, dout, exp_dout);
        if (!ab) begin
            repeat (hold) begin
                @(negedge clk);
                chk({tag, ".okhold"}, ram_ok, 1);
            end
        end
        ram_cs = 1'b0;
        vram_cs = 1'b0;
        @(negedge clk);
        chk({tag, ".end"}, {sdram_req, ram_ok}, 0);
    endtask

    initial begin
        rst = 1'b1; ram_cs = 1'b0; vram_cs = 1'b0; addr = '0; din = '0;
        UDSWn = 1'b1; LDSWn = 1'b1;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = '0;
        exp_dout = 16'hffff;
        #7;
        chk("rst.dout", dout, 16'hffff);
        chk("rst.ctl", {ram_ok, sdram_req, sdram_we, sdram_dsn}, 5'b00011);
        chk("rst.addr", sdram_addr, 0);
        chk("rst.din", sdram_din, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        xact(0, 14'h0123, 16'h1234, 1, 0, 1, 2, 16'h5555, 0, 0, "vram_bw");
        xact(1, 14'h0010, 16'h0000, 1, 1, 2, 3, 16'hbeef, 0, 1, "ram_rd");
        xact(1, 14'h0222, 16'h0000, 1, 1, 0, 3, 16'hcafe, 1, 0, "abort");
        idle(4, 1'b0);
        xact(0, 14'h0040, 16'h0000, 1, 1, 1, 1, 16'h0f0f, 0, 0, "rmw_rd");
        xact(0, 14'h0040, 16'h0ff0, 0, 1, 0, 2, 16'h0000, 0, 1, "rmw_wr");
        idle(2, 1'b1);

        // Two edges during WAIT: the later one survives in the pending slot
        ram_cs = 1'b1; addr = 14'h0200; UDSWn = 1'b1; LDSWn = 1'b1;
        @(negedge clk);
        chk("pend.req1", sdram_req, 1);
        chk("pend.addr1", sdram_addr, exp_addr(1, 14'h0200));
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        ram_cs = 1'b0;
        @(negedge clk);
        ram_cs = 1'b1; addr = 14'h0300; UDSWn = 1'b0; LDSWn = 1'b0;
        din = 16'haaaa;
        @(negedge clk);
        ram_cs = 1'b0;
        @(negedge clk);
        vram_cs = 1'b1; addr = 14'h1800; din = 16'h5a5a;
        @(negedge clk);
        chk("pend.busy", {sdram_req, ram_ok}, 0);
        sdram_rdy = 1'b1; sdram_dout = 16'h1357;
        @(negedge clk);
        sdram_rdy = 1'b0;
        exp_dout = 16'h1357;
        chk("pend.done", {sdram_req, ram_ok}, 0);
        chk("pend.dout", dout, exp_dout);
        @(negedge clk);
        chk("pend.gap", sdram_req, 0);
        @(negedge clk);
        chk("pend.req2", sdram_req, 1);
        chk("pend.addr2", sdram_addr, exp_addr(0, 14'h1800));
        chk("pend.we2", {sdram_we, sdram_dsn}, 3'b100);
        chk("pend.din2", sdram_din, 16'h5a5a);
        sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_dout = 16'h2468;
        @(negedge clk);
        sdram_ack = 1'b0; sdram_rdy = 1'b0;
        chk("pend.ok2", ram_ok, 1);
        chk("pend.dout2", dout, exp_dout);
        vram_cs = 1'b0;
        @(negedge clk);
        chk("pend.end", {sdram_req, ram_ok}, 0);
        idle(2, 1'b0);

        // Reset in the middle of a read
        ram_cs = 1'b1; addr = 14'h0abc; UDSWn = 1'b1; LDSWn = 1'b1;
        @(negedge clk);
        chk("rstw.req", sdram_req, 1);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        ram_cs = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstw.out", {sdram_req, ram_ok, sdram_we, sdram_dsn, dout},
            {5'b00011, 16'hffff});
        chk("rstw.addr", sdram_addr, 0);
        exp_dout = 16'hffff;
        @(negedge clk);
        rst = 1'b0;
        sdram_rdy = 1'b1; sdram_dout = 16'h7777;
        @(negedge clk);
        sdram_rdy = 1'b0;
        chk("rstw.rdy", {sdram_req, ram_ok, dout}, {2'b00, 16'hffff});
        idle(2, 1'b0);
        xact(1, 14'h0abc, 16'h0000, 1, 1, 1, 1, 16'h9abc, 0, 0, "rstw.next");

        for (int i = 0; i < 60; i++) begin
            bit ram, u, l, ab;
            int ad, rd;
            ram = 1'($urandom);
            u   = 1'($urandom);
            l   = 1'($urandom);
            ad  = $urandom_range(0, 3);
            rd  = $urandom_range(0, 3);
            ab  = (rd > 0) && ($urandom_range(0, 3) == 0);
            xact(ram, AW'($urandom), 16'($urandom), u, l, ad, rd,
                 16'($urandom), ab, $urandom_range(0, 2), "rnd");
            idle($urandom_range(0, 2), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
